product_accumulator: RTL and testbench

- Sequential stage directly downstream of the 4x4 binary multiplier.
- Accepts the multiplier's 8-bit products one per valid/ready handshake and sums COUNT consecutive products into a frame total (dot-product style).
- Presents the frame total on a valid/ready output port with a sticky saturation flag.
- Sits between the combinational multiplier and any consumer of accumulated results.

---
 rtl/product_accumulator_if.sv | 25 ++
 rtl/product_accumulator.sv | 103 ++++++++++
 tb/tb_product_accumulator.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer and the product accumulator.
// Latency: none, wires only.
// Backpressure: in_ready throttles the producer and out_ready throttles the result.
interface product_accumulator_if #(
    parameter int ACC_W = 16
) ();
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       product_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;

    modport master (
        output clear, in_valid, product_in, out_ready,
        input  in_ready, out_valid, acc_out, overflow
    );

    modport slave (
        input  clear, in_valid, product_in, out_ready,
        output in_ready, out_valid, acc_out, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive 8-bit products into a saturating frame total with a sticky overflow flag.
// Latency: result is visible the cycle after the handshake that accepts the last product of a frame.
// Backpressure: in_ready drops while a result is held; the result is held until out_ready.
module product_accumulator #(
    parameter int ACC_W = 16,
    parameter int COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    product_accumulator_if.slave  bus
);
    localparam int              CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W:0]   sum;
    logic             accept;

    // Next-state logic: clear dominates, then frame accumulation or result release.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // in_ready_q is what the producer sees, so the handshake is judged on it.
        accept  = bus.in_valid && in_ready_q;
        // One extra bit catches the carry out; its MSB means the frame saturated.
        sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, bus.product_in};

        if (bus.clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (sum[ACC_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end

        // Handshake outputs are registered decodes of the next state, so neither
        // in_valid nor out_ready has a combinational path to them.
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_HOLD);
    end

    // State and registered outputs; in_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed vector table, hand-written
// corner sequences on three parameterisations, and a randomized run against a frame-sum model.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(16)) ia ();
    product_accumulator_if #(.ACC_W(8))  ib ();
    product_accumulator_if #(.ACC_W(16)) ic ();

    product_accumulator #(.ACC_W(16), .COUNT(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    product_accumulator #(.ACC_W(8),  .COUNT(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    product_accumulator #(.ACC_W(16), .COUNT(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0][7:0] p;
        int              hold;
        int              exp_acc;
        logic            exp_ovf;
    } vec_t;

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int hold, input int acc, input logic ovf);
        vec_t v;
        v.p[0] = 8'(a); v.p[1] = 8'(b); v.p[2] = 8'(c); v.p[3] = 8'(d);
        v.hold = hold; v.exp_acc = acc; v.exp_ovf = ovf;
        return v;
    endfunction

    // Feed one 4-product frame on ia, hold the result for v.hold cycles while
    // offering an extra product, then take it.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        ia.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ia.in_valid   = 1'b1;
            ia.product_in = v.p[k];
            tick();
        end
        ia.in_valid = 1'b0;
        check({tag, "_valid"}, 32'(ia.out_valid), 1);
        check({tag, "_acc"}, 32'(ia.acc_out), v.exp_acc);
        check({tag, "_ovf"}, 32'(ia.overflow), 32'(v.exp_ovf));
        for (int h = 0; h < v.hold; h++) begin
            ia.in_valid   = 1'b1;
            ia.product_in = 8'd99;
            tick();
            check({tag, "_hold_valid"}, 32'(ia.out_valid), 1);
            check({tag, "_hold_acc"}, 32'(ia.acc_out), v.exp_acc);
            check({tag, "_hold_rdy"}, 32'(ia.in_ready), 0);
        end
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(ia.out_valid), 0);
        check({tag, "_post_acc"}, 32'(ia.acc_out), 0);
        check({tag, "_post_rdy"}, 32'(ia.in_ready), 1);
    endtask

    // Reference model for the randomized run: frame sums from accepted products.
    bit       rand_on = 1'b0;
    int       part_sum = 0;
    int       part_cnt = 0;
    int       exp_q[$];
    int       rand_results = 0;

    always @(negedge clk) begin
        if (rand_on) begin
            if (ia.clear) begin
                part_sum = 0;
                part_cnt = 0;
                if (ia.out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                if (ia.out_valid && ia.out_ready) begin
                    int e;
                    rand_results++;
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected_result", 32'(ia.acc_out), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rand_acc", 32'(ia.acc_out), (e > 65535) ? 65535 : e);
                        check("rand_ovf", 32'(ia.overflow), (e > 65535) ? 1 : 0);
                    end
                end
                if (ia.in_valid && ia.in_ready) begin
                    part_sum += int'(ia.product_in);
                    part_cnt++;
                    if (part_cnt == 4) begin
                        exp_q.push_back(part_sum);
                        part_sum = 0;
                        part_cnt = 0;
                    end
                end
            end
        end
    end

    vec_t vecs[4];

    initial begin
        vecs[0] = mk(6, 0, 8, 1, 3, 15, 1'b0);
        vecs[1] = mk(225, 225, 225, 225, 0, 900, 1'b0);
        vecs[2] = mk(0, 0, 0, 0, 1, 0, 1'b0);
        vecs[3] = mk(255, 1, 128, 7, 2, 391, 1'b0);

        ia.clear = 0; ia.in_valid = 0; ia.product_in = 0; ia.out_ready = 0;
        ib.clear = 0; ib.in_valid = 0; ib.product_in = 0; ib.out_ready = 0;
        ic.clear = 0; ic.in_valid = 0; ic.product_in = 0; ic.out_ready = 0;

        // Reset state
        rst_n = 1'b0;
        #3;
        check("rst_acc", 32'(ia.acc_out), 0);
        check("rst_valid", 32'(ia.out_valid), 0);
        check("rst_ovf", 32'(ia.overflow), 0);
        #9 rst_n = 1'b1;
        tick();
        check("rst_rdy_after", 32'(ia.in_ready), 1);

        // Directed vector table
        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Back-to-back frames with out_ready high: exactly one bubble per frame
        ia.out_ready = 1'b1;
        ia.in_valid = 1'b1;
        ia.product_in = 8'd225;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                check("b2b_rdy", 32'(ia.in_ready), 1);
                check("b2b_novalid", 32'(ia.out_valid), 0);
                tick();
            end
            check("b2b_valid", 32'(ia.out_valid), 1);
            check("b2b_acc", 32'(ia.acc_out), 32'h384);
            check("b2b_bubble", 32'(ia.in_ready), 0);
            tick();
        end
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b0;
        check("b2b_end_acc", 32'(ia.acc_out), 0);

        // Clear overrides a simultaneous handshake mid-frame
        ia.in_valid = 1'b1; ia.product_in = 8'd10; tick();
        ia.product_in = 8'd20; tick();
        ia.product_in = 8'd30; ia.clear = 1'b1; tick();
        ia.clear = 1'b0; ia.in_valid = 1'b0;
        check("clr_acc", 32'(ia.acc_out), 0);
        check("clr_valid", 32'(ia.out_valid), 0);
        check("clr_rdy", 32'(ia.in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            ia.in_valid = 1'b1; ia.product_in = 8'd1; tick();
            check("clr_frame_valid", 32'(ia.out_valid), (k == 3) ? 1 : 0);
        end
        ia.in_valid = 1'b0;
        check("clr_frame_acc", 32'(ia.acc_out), 4);
        // Clear while holding discards the result
        ia.clear = 1'b1; tick(); ia.clear = 1'b0;
        check("clr_hold_valid", 32'(ia.out_valid), 0);
        check("clr_hold_acc", 32'(ia.acc_out), 0);
        check("clr_hold_rdy", 32'(ia.in_ready), 1);

        // Asynchronous reset mid-frame
        ia.in_valid = 1'b1; ia.product_in = 8'd5; tick();
        ia.product_in = 8'd6; tick();
        ia.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_acc", 32'(ia.acc_out), 0);
        check("arst_valid", 32'(ia.out_valid), 0);
        check("arst_rdy", 32'(ia.in_ready), 0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_rdy_after", 32'(ia.in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            ia.in_valid = 1'b1; ia.product_in = 8'd2; tick();
            check("arst_frame_valid", 32'(ia.out_valid), (k == 3) ? 1 : 0);
        end
        ia.in_valid = 1'b0;
        check("arst_frame_acc", 32'(ia.acc_out), 8);
        ia.out_ready = 1'b1; tick(); ia.out_ready = 1'b0;

        // Saturation on the narrow instance, then a clean frame
        ib.in_valid = 1'b1; ib.product_in = 8'd200; tick();
        ib.product_in = 8'd100; tick();
        ib.in_valid = 1'b0;
        check("sat_valid", 32'(ib.out_valid), 1);
        check("sat_acc", 32'(ib.acc_out), 255);
        check("sat_ovf", 32'(ib.overflow), 1);
        ib.out_ready = 1'b1; tick(); ib.out_ready = 1'b0;
        check("sat_taken_ovf", 32'(ib.overflow), 0);
        ib.in_valid = 1'b1; ib.product_in = 8'd1; tick();
        ib.product_in = 8'd2; tick();
        ib.in_valid = 1'b0;
        check("sat_next_acc", 32'(ib.acc_out), 3);
        check("sat_next_ovf", 32'(ib.overflow), 0);
        ib.out_ready = 1'b1; tick(); ib.out_ready = 1'b0;

        // COUNT=1: every accepted product is a frame, with a bubble between accepts
        ic.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ic.in_valid = 1'b1;
            ic.product_in = 8'(7 + 2 * i);
            tick();
            check("c1_valid", 32'(ic.out_valid), 1);
            check("c1_acc", 32'(ic.acc_out), 7 + 2 * i);
            check("c1_rdy", 32'(ic.in_ready), 0);
            tick();
            check("c1_bubble_valid", 32'(ic.out_valid), 0);
            check("c1_bubble_acc", 32'(ic.acc_out), 0);
        end
        ic.in_valid = 1'b0;
        ic.out_ready = 1'b0;

        // Randomized traffic against the frame-sum model
        rand_on = 1'b1;
        for (int c = 0; c < 600; c++) begin
            ia.in_valid   = ($urandom_range(0, 9) < 7);
            ia.product_in = 8'($urandom_range(0, 255));
            ia.out_ready  = ($urandom_range(0, 9) < 6);
            ia.clear      = ($urandom_range(0, 99) < 3);
            tick();
            if (ia.in_ready && ia.out_valid)
                check("rand_rdy_valid_exclusive", 32'(ia.in_ready & ia.out_valid), 0);
        end
        ia.in_valid = 1'b0;
        ia.clear = 1'b0;
        ia.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        rand_on = 1'b0;
        check("rand_drain", 32'(exp_q.size()), 0);
        if (rand_results == 0) check("rand_any_result", 32'(rand_results), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
